mmio_link_port: RTL and testbench
=================================

// Module: mmio_link_port
// PURPOSE
//  Memory-mapped photonic-link port on the processor data bus, in parallel with data memory.
//  CPU stores to TX_DATA feed a TX FIFO, which drains onto the outbound link (valid/ready).
//  Inbound link words fill an RX FIFO; the CPU reads the RX head and pops it by a store.
//  mmio_hit tells the computer top to select mmio_data_out instead of data memory data_out.
// PARAMETERS
//  DATA_WIDTH  16       bus and link word width
//  ADDR_WIDTH  16       bus address width
//  MMIO_BASE   16'hFF00 base of the 8-word register window (bits [2:0] are the offset)
//  DEPTH       8        entries per FIFO (power of two, >=2)
// PORTS
//  clk                  in   1   clock, rising edge
//  rst                  in   1   reset; asynchronous, active-low
//  address_rw           in   16  processor data address
//  data_in              in   16  processor store data
//  memory_write_enable  in   1   processor store strobe
//  mmio_hit             out  1   address_rw is inside [MMIO_BASE, MMIO_BASE+7] (combinational)
//  mmio_data_out        out  16  read data for address_rw (combinational); 0 if no hit
//  tx_valid / tx_data   out  1/16  outbound word; tx_data = TX FIFO head
//  tx_ready             in   1   link accepts the word
//  rx_valid / rx_data   in   1/16  inbound word
//  rx_ready             out  1   = RX FIFO not full (registered state)
// BEHAVIOUR
//  Offsets: 0 TX_DATA(W), 1 RX_DATA(R, head, no pop), 2 STATUS(R), 3 RX_POP(W, data ignored),
//   4 CTRL(W: bit0 tx_enable, bit1 clear sticky flags; self-clearing), 5 TX_COUNT(R), 6 RX_COUNT(R);
//   7 and unused bits read 0, and writes to them are ignored.
//  STATUS: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty [4] tx_overflow [5] rx_underflow [6] tx_enable.
//  Reset (rst=0, async): both FIFOs empty, flags 0, tx_enable=1, tx_valid=0, rx_ready=1, counts=0.
//  Push: store to TX_DATA at edge N; word is at the head, and tx_valid=1 in cycle N+1 (1-cycle latency).
//  tx_valid = tx_enable && !tx_empty. Transfer occurs when tx_valid && tx_ready at the edge; the head pops.
//  tx_data is held stable while tx_valid && !tx_ready; tx_enable=0 drops tx_valid without losing data.
//  TX full: push is accepted only if a link pop happens in the same cycle (count unchanged);
//   otherwise the word is dropped and tx_overflow sets (sticky).
//  RX: accept when rx_valid && rx_ready; the word is readable at RX_DATA the cycle after. No drops possible.
//  RX_POP when empty is a no-op and sets rx_underflow (sticky). Pop and link push in the same cycle: both occur.
//  RX full with a simultaneous pop: rx_ready stays 0 that cycle (from registered count); no bypass.
//  Clear (CTRL bit1) in the same cycle as a new overflow/underflow: the set wins.
//  Counts: DATA_WIDTH-wide entry counts, range 0..DEPTH; pointers wrap modulo DEPTH.
//  memory_write_enable && !mmio_hit: block ignores it (data memory owns the store).
//  Reset mid-transfer flushes the FIFOs; words in flight are lost by design.
// STRUCTURE
//  Package link_port_pkg: offset localparams (OFF_TX_DATA..OFF_RX_COUNT), STATUS bit indices,
//   and typedef word_t = logic [15:0].
//  Sub-module sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/count/head, async active-low reset.
//   Instantiated twice (tx_fifo, rx_fifo). Top-level holds decode, CTRL/flags, read mux.
// TESTING
//  Reset, then read STATUS -> 16'h004A (tx_empty, rx_empty, tx_enable); rx_ready=1, tx_valid=0.
//  Store 16'hA5A5 to FF00, tx_ready=1 -> tx_valid=1 next cycle with tx_data=A5A5; TX_COUNT returns to 0.
//  tx_ready=0, push 9 words 1..9 -> words 1..8 held; STATUS[4]=1; drain order 1..8; CTRL=2 clears bit 4.
//  Drive rx 16'h1234,16'h5678 -> FF01 reads 1234; store FF03; FF01 reads 5678; RX_COUNT=1.
//  Fill RX to 8 -> rx_ready=0; pop and offer a word in the same cycle -> count 7, then refills to 8.
//  Store FF03 on empty RX -> STATUS[5]=1. Assert rst mid-burst -> tx_valid=0 immediately, counts 0.

Source files
------------

// File: rtl/link_port_pkg.sv
// Shared register-window offsets and STATUS/CTRL bit positions for the
// memory-mapped photonic link port.
package link_port_pkg;

  typedef logic [15:0] word_t;

  localparam logic [2:0] OFF_TX_DATA  = 3'd0;
  localparam logic [2:0] OFF_RX_DATA  = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_RX_POP   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_TX_COUNT = 3'd5;
  localparam logic [2:0] OFF_RX_COUNT = 3'd6;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_EMPTY     = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_UNDERFLOW = 5;
  localparam int ST_TX_ENABLE    = 6;

  localparam int CTRL_TX_ENABLE  = 0;
  localparam int CTRL_CLEAR      = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is
// taken only when a pop frees the slot at the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_link_port.sv
// MMIO link port: register-window decode, CTRL/sticky flags and read mux
// around a TX FIFO (CPU -> link) and an RX FIFO (link -> CPU).
module mmio_link_port
  import link_port_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 16'hFF00,
  parameter int                    DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_rw,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  memory_write_enable,
  output logic                  mmio_hit,
  output logic [DATA_WIDTH-1:0] mmio_data_out,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]            offset;
  logic                  bus_wr;
  logic                  tx_store;
  logic                  rx_pop_req;
  logic                  ctrl_wr;
  logic                  tx_pop;
  logic                  rx_push;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]         tx_count, rx_count;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  tx_enable;
  logic                  tx_overflow;
  logic                  rx_underflow;
  logic                  tx_overflow_set;
  logic                  rx_underflow_set;
  logic                  flag_clear;
  logic [DATA_WIDTH-1:0] status;

  assign offset     = address_rw[2:0];
  assign mmio_hit   = (address_rw[ADDR_WIDTH-1:3] == MMIO_BASE[ADDR_WIDTH-1:3]);
  assign bus_wr     = memory_write_enable && mmio_hit;
  assign tx_store   = bus_wr && (offset == OFF_TX_DATA);
  assign rx_pop_req = bus_wr && (offset == OFF_RX_POP);
  assign ctrl_wr    = bus_wr && (offset == OFF_CTRL);
  assign flag_clear = ctrl_wr && data_in[CTRL_CLEAR];

  assign tx_valid = tx_enable && !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  // rx_ready comes from the registered count, so a same-cycle pop never opens it early.
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_overflow_set  = tx_store && tx_full && !tx_pop;
  assign rx_underflow_set = rx_pop_req && rx_empty;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_store),
    .pop   (tx_pop),
    .din   (data_in),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop_req),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_enable    <= 1'b1;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (ctrl_wr) tx_enable <= data_in[CTRL_TX_ENABLE];
      if (tx_overflow_set)       tx_overflow <= 1'b1;
      else if (flag_clear)       tx_overflow <= 1'b0;
      if (rx_underflow_set)      rx_underflow <= 1'b1;
      else if (flag_clear)       rx_underflow <= 1'b0;
    end
  end

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_TX_OVERFLOW]  = tx_overflow;
    status[ST_RX_UNDERFLOW] = rx_underflow;
    status[ST_TX_ENABLE]    = tx_enable;
  end

  always_comb begin
    mmio_data_out = '0;
    if (mmio_hit) begin
      case (offset)
        OFF_RX_DATA:  mmio_data_out = rx_head;
        OFF_STATUS:   mmio_data_out = status;
        OFF_TX_COUNT: mmio_data_out = DATA_WIDTH'(tx_count);
        OFF_RX_COUNT: mmio_data_out = DATA_WIDTH'(rx_count);
        default:      mmio_data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_link_port.sv
// Directed bench for mmio_link_port: register reads, TX/RX FIFO flow,
// overflow/underflow flags, enable gating and asynchronous reset.
module tb_mmio_link_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address_rw;
  logic [15:0] data_in;
  logic        memory_write_enable;
  logic        mmio_hit;
  logic [15:0] mmio_data_out;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;

  int checks   = 0;
  int failures = 0;

  mmio_link_port dut (
    .clk                 (clk),
    .rst                 (rst),
    .address_rw          (address_rw),
    .data_in             (data_in),
    .memory_write_enable (memory_write_enable),
    .mmio_hit            (mmio_hit),
    .mmio_data_out       (mmio_data_out),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .tx_ready            (tx_ready),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_ready            (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Store at the next rising edge, leave the bus idle #1 after it.
  task automatic wr(input logic [15:0] addr, input logic [15:0] d);
    address_rw          = addr;
    data_in             = d;
    memory_write_enable = 1'b1;
    @(posedge clk);
    #1;
    memory_write_enable = 1'b0;
    address_rw          = 16'h0000;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    address_rw = addr;
    #1;
    chk(tag, mmio_data_out, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    address_rw = 16'h0000;
    data_in = 16'h0000;
    memory_write_enable = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = 16'h0000;
    #2;
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    tick();
    tick();
    rst = 1'b1;

    rdchk("status_after_reset", 16'hFF02, 16'h004A);
    chk("hit_in_window", {15'd0, mmio_hit}, 16'd1);
    rdchk("no_hit_data_zero", 16'h1234, 16'h0000);
    chk("no_hit_flag", {15'd0, mmio_hit}, 16'd0);
    rdchk("window_end_plus1", 16'hFF08, 16'h0000);
    chk("no_hit_ff08", {15'd0, mmio_hit}, 16'd0);

    // Single word with the link ready.
    tx_ready = 1'b1;
    wr(16'hFF00, 16'hA5A5);
    chk("push_tx_valid", {15'd0, tx_valid}, 16'd1);
    chk("push_tx_data", tx_data, 16'hA5A5);
    tick();
    chk("after_xfer_tx_valid", {15'd0, tx_valid}, 16'd0);
    rdchk("after_xfer_tx_count", 16'hFF05, 16'd0);

    // Nine words into an 8-deep FIFO with the link stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(16'hFF00, 16'(i));
    rdchk("ovf_tx_count", 16'hFF05, 16'd8);
    rdchk("ovf_status", 16'hFF02, 16'h0059);
    chk("stall_hold_data", tx_data, 16'd1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_word_%0d", i), tx_data, 16'(i));
      tick();
    end
    chk("drained_tx_valid", {15'd0, tx_valid}, 16'd0);

    // CTRL=2: clear sticky flags and disable TX.
    tx_ready = 1'b0;
    wr(16'hFF04, 16'h0002);
    rdchk("clear_status", 16'hFF02, 16'h000A);
    tx_ready = 1'b1;
    wr(16'hFF00, 16'h0077);
    chk("disabled_tx_valid", {15'd0, tx_valid}, 16'd0);
    rdchk("disabled_kept_count", 16'hFF05, 16'd1);
    tx_ready = 1'b0;
    wr(16'hFF04, 16'h0001);
    chk("reenable_tx_valid", {15'd0, tx_valid}, 16'd1);
    chk("reenable_tx_data", tx_data, 16'h0077);
    tx_ready = 1'b1;
    tick();
    rdchk("reenable_drained", 16'hFF05, 16'd0);

    // Store into a full TX FIFO while the link pops: accepted, no overflow.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(16'hFF00, 16'h0010 + 16'(i));
    tx_ready = 1'b1;
    wr(16'hFF00, 16'h0099);
    rdchk("full_swap_count", 16'hFF05, 16'd8);
    rdchk("full_swap_status", 16'hFF02, 16'h0049);
    chk("full_swap_head", tx_data, 16'h0011);
    repeat (7) tick();
    chk("full_swap_last", tx_data, 16'h0099);
    tick();
    chk("full_swap_empty", {15'd0, tx_valid}, 16'd0);
    tx_ready = 1'b0;

    // RX path.
    rx_valid = 1'b1;
    rx_data  = 16'h1234;
    tick();
    rx_data  = 16'h5678;
    tick();
    rx_valid = 1'b0;
    rdchk("rx_head_first", 16'hFF01, 16'h1234);
    wr(16'hFF03, 16'hDEAD);
    rdchk("rx_head_second", 16'hFF01, 16'h5678);
    rdchk("rx_count_one", 16'hFF06, 16'd1);

    rx_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rx_data = 16'h0100 + 16'(i);
      tick();
    end
    rx_valid = 1'b0;
    rdchk("rx_full_count", 16'hFF06, 16'd8);
    chk("rx_full_ready", {15'd0, rx_ready}, 16'd0);
    rdchk("rx_full_status", 16'hFF02, 16'h0046);

    // Pop while a word is offered to a full RX FIFO: no bypass.
    rx_valid = 1'b1;
    rx_data  = 16'hBEEF;
    wr(16'hFF03, 16'h0000);
    rdchk("rx_pop_full_count", 16'hFF06, 16'd7);
    chk("rx_pop_full_ready", {15'd0, rx_ready}, 16'd1);
    tick();
    rx_valid = 1'b0;
    rdchk("rx_refill_count", 16'hFF06, 16'd8);
    rdchk("rx_refill_head", 16'hFF01, 16'h0100);

    for (int i = 0; i < 8; i++) wr(16'hFF03, 16'h0000);
    rdchk("rx_drained_count", 16'hFF06, 16'd0);
    wr(16'hFF03, 16'h0000);
    rdchk("rx_underflow_status", 16'hFF02, 16'h006A);
    rdchk("rx_underflow_count", 16'hFF06, 16'd0);
    wr(16'hFF04, 16'h0003);
    rdchk("clear_keep_enable", 16'hFF02, 16'h004A);

    // Ignored stores: offset 7 and outside the window.
    wr(16'hFF07, 16'hFFFF);
    rdchk("off7_reads_zero", 16'hFF07, 16'h0000);
    wr(16'h1000, 16'hCAFE);
    rdchk("miss_store_ignored", 16'hFF05, 16'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) wr(16'hFF00, 16'h0200 + 16'(i));
    chk("burst_tx_valid", {15'd0, tx_valid}, 16'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    rdchk("async_rst_tx_count", 16'hFF05, 16'd0);
    tick();
    rst = 1'b1;
    rdchk("post_rst_status", 16'hFF02, 16'h004A);
    chk("post_rst_rx_ready", {15'd0, rx_ready}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
